// File: rtl/fifo2axis_pkg.sv
// Shared types and helpers for the fifo2axis packetizer.
//   state_e   : packetizer FSM states (IDLE, FILL, SEND)
//   clamp_len : maps a requested packet length onto 1..depth
package fifo2axis_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SEND = 2'd2
  } state_e;

  // A length of zero, or one the buffer cannot hold, becomes a full-buffer packet.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
    int unsigned res;
    if ((len == 0) || (len > depth)) res = depth;
    else                             res = len;
    return res;
  endfunction

endpackage

// File: rtl/fifo2axis_buf.sv
// Circular word buffer used by the fifo2axis packetizer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointers/occupancy only)
//   push_i     : write wdata_i at the write pointer this cycle
//   pop_i      : advance the read pointer this cycle
//   wdata_i    : word to store
//   rdata_o    : word at the read pointer (combinational)
//   occ_o      : number of stored words, 0..DEPTH
// The caller guarantees no push when full and no pop when empty.
module fifo2axis_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  localparam int PW        = $clog2(DEPTH),
  localparam int OW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [OW-1:0]         occ_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]         occ_q, occ_d;

  // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
    occ_d = occ_q + OW'(push_i) - OW'(pop_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage carries no reset; only handshaked words are ever read back.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign occ_o   = occ_q;

endmodule

// File: rtl/fifo2axis_pkt.sv
// Packetizer from a producer word stream to an AXI4-Stream master.
// Buffers up to DEPTH words and sends them as one packet of run-time length,
// marking the final beat with tlast.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, pkt_len  : begin a packet (IDLE only); length sampled on acceptance
//   in_data/in_valid/in_ready          : producer side
//   m_axis_tdata/tvalid/tready/tlast   : stream side
//   start_accel     : accelerator enable, high from the first edge after reset
//   busy            : FSM not in IDLE
//   done            : one-cycle pulse after the last beat is accepted
//   dbg_state       : current FSM state (state_e encoding)
//
// Handshakes: a transfer happens on a clock edge where valid && ready are both
// high. Valid never depends on ready; once tvalid is raised it stays high with
// tdata/tlast unchanged until tready is seen, because occupancy can only grow
// and rd_cnt only moves on an accepted beat.
module fifo2axis_pkt
  import fifo2axis_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 4,
  parameter int CUT_THROUGH = 0,
  parameter int LW          = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LW-1:0]         pkt_len,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  start_accel,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state
);

  state_e          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [LW-1:0]   rd_cnt_q, rd_cnt_d;
  logic            done_q, done_d;
  logic            start_accel_q;

  logic [LW-1:0]         occ;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  push, pop;
  logic                  last_beat;
  logic                  send_cond;

  fifo2axis_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i(in_data),
    .rdata_o(rdata),
    .occ_o  (occ)
  );

  assign in_ready      = (state_q != IDLE) && (wr_cnt_q < len_q) && (occ < LW'(DEPTH));
  assign m_axis_tvalid = (state_q == SEND) && (occ != '0);
  assign last_beat     = (rd_cnt_q == (len_q - LW'(1)));
  assign m_axis_tlast  = m_axis_tvalid && last_beat;
  // Gated so the idle/reset value is 0 even though the storage is not reset.
  assign m_axis_tdata  = m_axis_tvalid ? rdata : '0;

  assign push = in_valid && in_ready;
  assign pop  = m_axis_tvalid && m_axis_tready;

  // Store-and-forward waits for the whole packet; cut-through for any word.
  assign send_cond = (CUT_THROUGH != 0) ? (occ != '0) : (wr_cnt_q == len_q);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    done_d   = 1'b0;
    if (push) wr_cnt_d = wr_cnt_q + LW'(1);
    if (pop)  rd_cnt_d = rd_cnt_q + LW'(1);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = FILL;
          len_d    = LW'(clamp_len(32'(pkt_len), 32'(DEPTH)));
          wr_cnt_d = '0;
          rd_cnt_d = '0;
        end
      end
      FILL: begin
        if (send_cond) state_d = SEND;
      end
      SEND: begin
        if (pop && last_beat) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      len_q         <= '0;
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      done_q        <= 1'b0;
      start_accel_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      done_q        <= done_d;
      start_accel_q <= 1'b1;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign start_accel = start_accel_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fifo2axis_pkt.sv
module tb_fifo2axis_pkt;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LW    = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // index 0: store-and-forward instance, index 1: cut-through instance
  logic          start_s  [2];
  logic [LW-1:0] len_s    [2];
  logic [DW-1:0] din_s    [2];
  logic          vin_s    [2];
  logic          rdy_s    [2];
  logic [DW-1:0] tdata_s  [2];
  logic          tvalid_s [2];
  logic          tready_s [2];
  logic          tlast_s  [2];
  logic          sacc_s   [2];
  logic          busy_s   [2];
  logic          done_s   [2];
  logic [1:0]    dbg_s    [2];

  fifo2axis_pkt #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CUT_THROUGH(0)) dut_sf (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .pkt_len(len_s[0]),
    .in_data(din_s[0]), .in_valid(vin_s[0]), .in_ready(rdy_s[0]),
    .m_axis_tdata(tdata_s[0]), .m_axis_tvalid(tvalid_s[0]), .m_axis_tready(tready_s[0]),
    .m_axis_tlast(tlast_s[0]), .start_accel(sacc_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .dbg_state(dbg_s[0])
  );

  fifo2axis_pkt #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CUT_THROUGH(1)) dut_ct (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .pkt_len(len_s[1]),
    .in_data(din_s[1]), .in_valid(vin_s[1]), .in_ready(rdy_s[1]),
    .m_axis_tdata(tdata_s[1]), .m_axis_tvalid(tvalid_s[1]), .m_axis_tready(tready_s[1]),
    .m_axis_tlast(tlast_s[1]), .start_accel(sacc_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .dbg_state(dbg_s[1])
  );

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  bit            done_pend [2];
  logic [DW-1:0] exp_q [$];

  typedef struct {
    int m;
    int len;
    int exp_beats;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int m, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start_s[m] = 1'b0; vin_s[m] = 1'b0; tready_s[m] = 1'b0;
      #2;
      chk("idle_done", done_s[m], done_pend[m]);
      done_pend[m] = 1'b0;
      chk("idle_busy", busy_s[m], 0);
      chk("idle_tvalid", tvalid_s[m], 0);
      chk("idle_in_ready", rdy_s[m], 0);
    end
  endtask

  // One packet on instance m. Input pattern: every vper-th cycle (vper>0) or
  // random with vprob percent. tready: low for rdelay cycles, then every
  // rper-th cycle or random with rprob percent. stop_after>0 ends the task
  // after that many beats (packet left unfinished).
  // Reference model: words accepted go into exp_q; sending phase starts one
  // cycle after the whole packet is in (store-and-forward) or after any word is
  // buffered (cut-through); output order, tlast position, occupancy bound,
  // in_ready/tvalid rules and the done pulse are checked every cycle.
  task automatic run_pkt(input int m, input int len, input logic [DW-1:0] base,
                         input int step, input int vper, input int vprob,
                         input int rper, input int rprob, input int rdelay,
                         input int stop_after,
                         output int nbeats, output logic [DW-1:0] last_data);
    int eff, n_in, n_out, phase;
    bit prev_stall, fin;
    logic [DW-1:0] prev_data;
    eff = (len == 0 || len > DEPTH) ? DEPTH : len;
    exp_q.delete();
    n_in = 0; n_out = 0; phase = 0; prev_stall = 0; fin = 0;
    prev_data = '0; nbeats = 0; last_data = '0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      bit vin, trd, exp_ready, exp_valid, cond;
      @(negedge clk);
      vin = (vper > 0) ? ((cyc % vper) == 0) : ($urandom_range(99) < vprob);
      if (cyc < rdelay)  trd = 1'b0;
      else if (rper > 0) trd = (((cyc - rdelay) % rper) == 0);
      else               trd = ($urandom_range(99) < rprob);
      start_s[m]  = (cyc == 0);
      len_s[m]    = LW'(len);
      vin_s[m]    = vin;
      din_s[m]    = base + DW'(n_in * step);
      tready_s[m] = trd;
      #2;
      chk("done", done_s[m], done_pend[m]);
      done_pend[m] = 1'b0;
      exp_ready = (phase != 0) && (n_in < eff) && ((n_in - n_out) < DEPTH);
      exp_valid = (phase == 2) && (n_in > n_out);
      chk("busy", busy_s[m], phase != 0);
      chk("in_ready", rdy_s[m], exp_ready);
      chk("tvalid", tvalid_s[m], exp_valid);
      if (prev_stall) begin
        chk("stall_tvalid", tvalid_s[m], 1);
        chk("stall_tdata", tdata_s[m], prev_data);
      end
      if (exp_valid && exp_q.size() > 0) begin
        chk("tdata", tdata_s[m], exp_q[0]);
        chk("tlast", tlast_s[m], n_out == eff - 1);
      end else begin
        chk("tlast_quiet", tlast_s[m], 0);
      end
      prev_stall = tvalid_s[m] && !trd;
      prev_data  = tdata_s[m];
      cond = (m == 0) ? (n_in == eff) : (n_in > n_out);
      if (phase == 0)              phase = 1;
      else if (phase == 1 && cond) phase = 2;
      if (vin && rdy_s[m]) begin
        exp_q.push_back(din_s[m]);
        n_in++;
      end
      if (tvalid_s[m] && trd) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        n_out++;
        nbeats++;
        if (tlast_s[m]) last_data = tdata_s[m];
        if (n_out == eff) begin
          phase = 0;
          done_pend[m] = 1'b1;
          fin = 1'b1;
        end
        if (stop_after > 0 && n_out == stop_after) fin = 1'b1;
      end
      chk("occ_bound", (n_in - n_out) <= DEPTH, 1);
    end
    chk("pkt_complete", fin, 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int nb, eff, len, m;
    logic [DW-1:0] ld;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 0; len_s[i] = '0; din_s[i] = '0; vin_s[i] = 0; tready_s[i] = 0;
      done_pend[i] = 0;
    end
    vecs[0] = '{0, 0, 4};
    vecs[1] = '{0, 7, 4};
    vecs[2] = '{0, 1, 1};
    vecs[3] = '{1, 1, 1};
    vecs[4] = '{1, 0, 4};
    vecs[5] = '{1, 5, 4};
    vecs[6] = '{0, 3, 3};
    vecs[7] = '{1, 2, 2};

    // reset values
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_tvalid", tvalid_s[i], 0);
      chk("rst_tlast", tlast_s[i], 0);
      chk("rst_tdata", tdata_s[i], 0);
      chk("rst_in_ready", rdy_s[i], 0);
      chk("rst_busy", busy_s[i], 0);
      chk("rst_done", done_s[i], 0);
      chk("rst_start_accel", sacc_s[i], 0);
    end
    rst_n = 1'b1;
    #1;
    chk("start_accel_pre_edge", sacc_s[0], 0);
    @(posedge clk); #1;
    chk("start_accel_sf", sacc_s[0], 1);
    chk("start_accel_ct", sacc_s[1], 1);

    // store-and-forward 0x11..0x44, then a back-to-back backpressured packet
    run_pkt(0, 4, 32'h11, 'h11, 1, 0, 1, 0, 0, 0, nb, ld);
    chk("sf_beats", nb, 4);
    chk("sf_last_data", ld, 32'h44);
    run_pkt(0, 4, 32'h50, 1, 1, 0, 3, 0, 0, 0, nb, ld);
    chk("bp_beats", nb, 4);
    chk("bp_last_data", ld, 32'h53);
    idle_cycles(0, 2);

    // cut-through with a word every third cycle
    run_pkt(1, 4, 32'hA0, 1, 3, 0, 1, 0, 0, 0, nb, ld);
    chk("ct_beats", nb, 4);
    chk("ct_last_data", ld, 32'hA3);
    idle_cycles(1, 1);

    // cut-through, full buffer while tready is held low
    run_pkt(1, 4, 32'hB0, 1, 1, 0, 1, 0, 10, 0, nb, ld);
    chk("full_beats", nb, 4);
    chk("full_last_data", ld, 32'hB3);
    idle_cycles(1, 1);

    // length table
    for (int i = 0; i < 8; i++) begin
      logic [DW-1:0] b;
      b = DW'(32'h100 * (i + 1));
      run_pkt(vecs[i].m, vecs[i].len, b, 1, 1, 0, 1, 0, 0, 0, nb, ld);
      chk("tbl_beats", nb, vecs[i].exp_beats);
      chk("tbl_last_data", ld, b + DW'(vecs[i].exp_beats - 1));
      idle_cycles(vecs[i].m, 1);
    end

    // randomized packets
    for (int i = 0; i < 40; i++) begin
      m   = $urandom_range(1);
      len = $urandom_range(7);
      eff = (len == 0 || len > DEPTH) ? DEPTH : len;
      run_pkt(m, len, $urandom, 1, 0, $urandom_range(100, 30), 0,
              $urandom_range(100, 30), $urandom_range(3), 0, nb, ld);
      chk("rand_beats", nb, eff);
      idle_cycles(m, 1);
    end

    // reset in the middle of a packet
    run_pkt(0, 4, 32'h77, 1, 1, 0, 1, 0, 0, 2, nb, ld);
    chk("abort_beats", nb, 2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", tvalid_s[0], 0);
    chk("mid_rst_tlast", tlast_s[0], 0);
    chk("mid_rst_tdata", tdata_s[0], 0);
    chk("mid_rst_busy", busy_s[0], 0);
    chk("mid_rst_in_ready", rdy_s[0], 0);
    chk("mid_rst_done", done_s[0], 0);
    chk("mid_rst_start_accel", sacc_s[0], 0);
    done_pend[0] = 0;
    done_pend[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_pkt(0, 2, 32'hC0, 1, 1, 0, 1, 0, 0, 0, nb, ld);
    chk("post_rst_beats", nb, 2);
    chk("post_rst_last_data", ld, 32'hC1);
    idle_cycles(0, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
